// File: rtl/vdp_sprite_hit_list_builder.sv
// vdp_sprite_hit_list_builder
//
// Per-line sprite scanner for the sprite renderer. Each accepted start walks
// the sprite y_block table once, one sprite per cycle. Every sprite that
// intersects the latched render line gets a hit list entry. A terminating
// entry is always written at the end of the scan.
//
// Ports
//   clk                    pixel clock
//   resetn                 asynchronous active-low reset
//   start                  scan request pulse, ignored while busy
//   render_line[8:0]       line being prepared, sampled on an accepted start
//   busy                   scan in progress (through the terminator write)
//   done                   one-cycle pulse after the terminator write
//   overflow               a hit was dropped in the current or last scan
//   sprite_meta_address    y_block read address (1-cycle read latency)
//   sprite_y[8:0]          sprite top line
//   height_select          0 = 8 lines, 1 = 16 lines
//   width_select           0 = 8 px, 1 = 16 px, forwarded into the entry
//   hit_list_write_en      hit list RAM write strobe
//   hit_list_write_address hit list RAM write address
//   hit_list_write_data    {ended, width_select, line_offset[3:0], sprite_id[7:0]}
module vdp_sprite_hit_list_builder #(
    parameter int SPRITE_COUNT = 256,
    parameter int MAX_HITS     = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [8:0]  render_line,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  sprite_meta_address,
    input  logic [8:0]  sprite_y,
    input  logic        height_select,
    input  logic        width_select,
    output logic        hit_list_write_en,
    output logic [7:0]  hit_list_write_address,
    output logic [13:0] hit_list_write_data
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SCAN      = 3'd1;
    localparam logic [2:0] S_FLUSH     = 3'd2;
    localparam logic [2:0] S_TERMINATE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [7:0] LAST_ADDR = 8'(SPRITE_COUNT - 1);
    // Highest usable entry count; the final slot is reserved for the terminator.
    localparam logic [7:0] HIT_CAP   = 8'(MAX_HITS - 1);

    localparam logic [13:0] TERMINATOR = {1'b1, 13'd0};

    // 9-bit wrap-around distance from the sprite top to the render line, so a
    // sprite starting near line 511 still hits lines 0.. correctly.
    function automatic logic [8:0] line_delta(input logic [8:0] line,
                                              input logic [8:0] top);
        return line - top;
    endfunction

    function automatic logic [13:0] hit_entry(input logic       wide,
                                              input logic [3:0] offset,
                                              input logic [7:0] id);
        return {1'b0, wide, offset, id};
    endfunction

    logic [2:0]  state;
    logic [8:0]  line_r;
    logic [7:0]  meta_addr_p0;
    logic        vld_p1;
    logic [7:0]  id_p1;
    logic [7:0]  hit_cnt;
    logic        we_p2;
    logic [7:0]  waddr_p2;
    logic [13:0] wdata_p2;
    logic        ovf_p2;
    logic        done_p2;

    logic        accept;
    logic [8:0]  delta_p1;
    logic        hit_p1;

    assign accept = (state == S_IDLE) && start;

    // ---- stage p0 -> p1: address issued, table data returns next cycle ----
    always_ff @(posedge clk) begin
        if (accept) begin
            line_r <= render_line;
        end
        id_p1 <= meta_addr_p0;
    end

    // ---- stage p1: hit test on returned table data ----
    always_comb begin
        delta_p1 = line_delta(line_r, sprite_y);
        hit_p1   = vld_p1 && (delta_p1 < (height_select ? 9'd16 : 9'd8));
    end

    // ---- stage p1 -> p2: registered hit list writes and control ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            meta_addr_p0 <= 8'd0;
            vld_p1       <= 1'b0;
            hit_cnt      <= 8'd0;
            we_p2        <= 1'b0;
            waddr_p2     <= 8'd0;
            wdata_p2     <= 14'd0;
            ovf_p2       <= 1'b0;
            done_p2      <= 1'b0;
        end else begin
            we_p2   <= 1'b0;
            done_p2 <= 1'b0;
            vld_p1  <= (state == S_SCAN);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_SCAN;
                        meta_addr_p0 <= 8'd0;
                        hit_cnt      <= 8'd0;
                        ovf_p2       <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (meta_addr_p0 == LAST_ADDR) begin
                        state <= S_FLUSH;
                    end else begin
                        meta_addr_p0 <= meta_addr_p0 + 8'd1;
                    end
                end
                S_FLUSH: begin
                    state <= S_TERMINATE;
                end
                S_TERMINATE: begin
                    // The last sprite's write has already updated hit_cnt here.
                    state    <= S_DONE;
                    we_p2    <= 1'b1;
                    waddr_p2 <= hit_cnt;
                    wdata_p2 <= TERMINATOR;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_p2 <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (hit_p1) begin
                if (hit_cnt < HIT_CAP) begin
                    we_p2    <= 1'b1;
                    waddr_p2 <= hit_cnt;
                    wdata_p2 <= hit_entry(width_select, delta_p1[3:0], id_p1);
                    hit_cnt  <= hit_cnt + 8'd1;
                end else begin
                    ovf_p2 <= 1'b1;
                end
            end
        end
    end

    assign busy                   = (state != S_IDLE);
    assign done                   = done_p2;
    assign overflow               = ovf_p2;
    assign sprite_meta_address    = meta_addr_p0;
    assign hit_list_write_en      = we_p2;
    assign hit_list_write_address = waddr_p2;
    assign hit_list_write_data    = wdata_p2;

endmodule

// File: doc/vdp_sprite_hit_list_builder.md
# vdp_sprite_hit_list_builder

Per-line sprite scanner that sits directly upstream of the sprite renderer. On each `start` it walks the sprite y_block table once, one sprite per cycle. For every sprite that intersects `render_line` it writes a hit list entry into the hit list RAM. It then writes a terminating entry, which the renderer uses to stop reading.

## Interface
- `SPRITE_COUNT`, default 256: number of y_block entries scanned. Range 1..256.
- `MAX_HITS`, default 64: hit list RAM depth in entries, including the terminator. Range 2..256.

- `clk` in 1: pixel clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins a scan. Ignored while `busy`.
- `render_line` in 9: line being prepared. Sampled on the accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the terminator write cycle.
- `done` out 1: one-cycle pulse, the cycle after the terminator write.
- `overflow` out 1: at least one hit was dropped in the current or last scan. Cleared on `start`.
- `sprite_meta_address` out 8: y_block read address. RAM read latency is exactly 1 cycle.
- `sprite_y` in 9: sprite top line.
- `height_select` in 1: 0 = 8 lines, 1 = 16 lines.
- `width_select` in 1: 0 = 8 px, 1 = 16 px. Forwarded unchanged.
- `hit_list_write_en` out 1: hit list RAM write strobe.
- `hit_list_write_address` out 8: hit list RAM write address.
- `hit_list_write_data` out 14: `{ended[13], width_select[12], line_offset[11:8], sprite_id[7:0]}`.

## Operation
- States: IDLE, SCAN, FLUSH, TERMINATE, DONE.
  - IDLE: `start` transitions to SCAN. It latches `render_line`, clears the hit count and clears `overflow`.
  - SCAN: issues addresses 0..SPRITE_COUNT-1, one per cycle, with no stalls. After the last address it goes to FLUSH.
  - FLUSH: one cycle, in which the last sprite's data is evaluated. Then TERMINATE.
  - TERMINATE: writes the terminator. Then DONE.
  - DONE: pulses `done`. Then IDLE.
- Hit test, for each returned entry k:
  - `delta = (line_r - sprite_y) mod 512`, 9-bit wrap-around subtraction.
  - Hit when `delta < (height_select ? 16 : 8)`.
  - `line_offset = delta[3:0]`. Bit 3 is 0 for 8-line sprites by construction.
  - Sprites wrapping past line 511 hit lines 0.. correctly.
- On a hit with hit count < MAX_HITS-1:
  - Write `{0, width_select, line_offset, k}` at address = hit count.
  - Increment the hit count.
- On a hit with hit count = MAX_HITS-1: no write, set `overflow`.
- Terminator: `{1, 13'b0}` at address = final hit count. It is always written, so the list is never left unterminated.
- Entries are written in ascending sprite_id order.
- The write address and hit count never exceed MAX_HITS-1. No wrap.
- `start` while busy: ignored, with no effect on the state, outputs or `overflow`.
- `resetn` low at any time, including mid-scan:
  - Immediately returns to IDLE.
  - All outputs go to 0: `busy`, `done`, `overflow`, `hit_list_write_en`, `hit_list_write_address`, `hit_list_write_data`, `sprite_meta_address`.
  - Any partial list is abandoned with no terminator. The consumer must not read it until the next `done`.

## Timing
- Accepted `start` at edge T:
  - `busy`=1 and `sprite_meta_address`=0 during cycle T+1.
  - Address k is presented in cycle T+1+k.
  - `sprite_y`/`height_select`/`width_select` for k are valid in cycle T+2+k.
- All hit list write outputs are registered. The write for sprite k appears in cycle T+3+k. `hit_list_write_en` is low on non-hit cycles.
- Terminator write in cycle T+SPRITE_COUNT+3. `busy` is still 1 in this cycle.
- `done`=1 and `busy`=0 in cycle T+SPRITE_COUNT+4.
- A new `start` is accepted in that same cycle. Back-to-back scan period is SPRITE_COUNT+4 cycles.
- Scan length is independent of the hit count and of overflow, so the timing is deterministic.
- `overflow` rises in the cycle of the dropped hit's would-be write (T+3+k) and holds until the next accepted `start`.

## Test plan
- Basic hits, SPRITE_COUNT=256:
  - Stimulus: `render_line`=100; sprite 5 y=95 h8; sprite 9 y=90 h16 w16; all others y=300.
  - Required: entries {5, off 5, w0} at address 0 and {9, off 10, w1} at address 1; terminator at address 2 in cycle T+259; `done` at T+260.
- Height boundary:
  - Stimulus: y=100 h8 with lines 107 and 108; y=100 h16 with lines 115 and 116.
  - Required: hits at 107 (off 7) and 115 (off 15); no hits at 108 or 116.
- Wrap:
  - Stimulus: sprite y=508 h16; `render_line`=3.
  - Required: hit with line_offset 7.
- Overflow, MAX_HITS=4:
  - Stimulus: sprites 0..5 all hit.
  - Required: ids 0,1,2 at addresses 0..2; terminator at address 3; `overflow`=1 from the sprite-3 slot; `done` timing unchanged.
- Control and reset:
  - Stimulus: `start` pulsed mid-scan.
  - Required: ignored; `overflow` unchanged.
  - Stimulus: `resetn` low at T+50.
  - Required: all outputs 0 asynchronously; a following `start` produces a clean full list.
